// File: rtl/uart_rx_if.sv
// uart_rx_if: serial input, frame controls and received-frame status of uart_rx.
// slave = receiver side, master = host/bench side.
interface uart_rx_if;
  logic       sin;
  logic       parity;
  logic       re;
  logic [8:0] dout;
  logic       ready;
  logic       framing_err;
  logic       overrun;
  logic       break_det;

  modport slave (
    input  sin, parity, re,
    output dout, ready, framing_err, overrun, break_det
  );

  modport master (
    output sin, parity, re,
    input  dout, ready, framing_err, overrun, break_det
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver, 8 data bits, optional raw parity.
// Ports: rxclk (16x baud clock), reset_n (async low), bus (uart_rx_if.slave):
//   sin/parity/re in; dout[8:0], ready, framing_err, overrun, break_det out.
// Optional break detection: define UART_RX_BREAK_EN.
module uart_rx (
  input  logic      rxclk,
  input  logic      reset_n,
  uart_rx_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_RX_BREAK_EN
    , S_BREAK
`endif
  } state_t;

  state_t     state_q;
  logic       sync1_q;
  logic       line_q;
  logic       prev_q;
  logic [7:0] tick_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       par_en_q;
  logic       par_bit_q;
  logic [8:0] dout_q;
  logic       ready_q;
  logic       ferr_q;
  logic       ovr_q;
`ifdef UART_RX_BREAK_EN
  logic       brk_q;
`endif

  logic mid;
  logic ack;

  // Bit centres fall on ticks 8, 24, 40, ... (tick 0 = detected falling edge)
  assign mid = (tick_q[3:0] == 4'h8);
  assign ack = bus.re & ready_q;

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      line_q    <= 1'b1;
      prev_q    <= 1'b1;
      tick_q    <= 8'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      dout_q    <= 9'h000;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_BREAK_EN
      brk_q     <= 1'b0;
`endif
    end else begin
      sync1_q <= bus.sin;
      line_q  <= sync1_q;
      prev_q  <= line_q;
      tick_q  <= tick_q + 8'd1;

      if (ack) begin
        ready_q <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
      end

      unique case (state_q)
        S_IDLE: begin
          // the edge that leaves IDLE is tick 0, so the next one is tick 1
          tick_q <= 8'd1;
          bit_q  <= 3'd0;
          if (!line_q && prev_q)
            state_q <= S_START;
        end
        S_START: begin
          if (tick_q == 8'd8) begin
            if (line_q) begin
              state_q <= S_IDLE;
            end else begin
              par_en_q  <= bus.parity;
              par_bit_q <= 1'b0;
              state_q   <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (mid) begin
            shift_q <= {line_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7)
              state_q <= par_en_q ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (mid) begin
            par_bit_q <= line_q;
            state_q   <= S_STOP;
          end
        end
        S_STOP: begin
          if (mid) begin
            state_q <= S_IDLE;
`ifdef UART_RX_BREAK_EN
            if (shift_q == 8'h00 && !par_bit_q && !line_q) begin
              state_q <= S_BREAK;
              brk_q   <= 1'b1;
            end else
`endif
            if (!ready_q || bus.re) begin
              dout_q  <= {par_bit_q, shift_q};
              ready_q <= 1'b1;
              ferr_q  <= ~line_q;
              ovr_q   <= 1'b0;
            end else begin
              ovr_q   <= 1'b1;
            end
          end
        end
`ifdef UART_RX_BREAK_EN
        S_BREAK: begin
          if (line_q) begin
            state_q <= S_IDLE;
            brk_q   <= 1'b0;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.dout        = dout_q;
  assign bus.ready       = ready_q;
  assign bus.framing_err = ferr_q;
  assign bus.overrun     = ovr_q;
`ifdef UART_RX_BREAK_EN
  assign bus.break_det   = brk_q;
`else
  assign bus.break_det   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16x 115.2k baud.
// Frames are driven bit by bit; expected dout is queued at drive time.
`timescale 1ns/10ps
module tb_uart_rx;

  logic rxclk;
  logic reset_n;
  uart_rx_if bus();

  uart_rx u_dut (
    .rxclk   (rxclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks;
  int failures;
  int cyc;
  int start_cyc;
  int rise_cyc;
  logic rdy_prev;
  logic [8:0] exp_q[$];

  initial rxclk = 1'b0;
  always #271.27 rxclk = ~rxclk;

  always @(posedge rxclk) cyc <= cyc + 1;

  always @(negedge rxclk) begin
    if (bus.ready && !rdy_prev && rise_cyc < 0)
      rise_cyc = cyc;
    rdy_prev = bus.ready;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: run did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic send_frame(input logic [7:0] d, input logic pb,
                            input logic stp, input bit push,
                            input int abort_at, output bit aborted);
    logic [10:0] bits;
    int nb;
    int n;
    aborted = 1'b0;
    bits = 11'h7ff;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (bus.parity) begin
      bits[9] = pb;
      bits[10] = stp;
      nb = 11;
    end else begin
      bits[9] = stp;
      nb = 10;
    end
    if (push)
      exp_q.push_back({bus.parity ? pb : 1'b0, d});
    rise_cyc = -1;
    start_cyc = cyc;
    n = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 16; c++) begin
        if (n == abort_at) begin
          bus.sin = 1'b1;
          reset_n = 1'b0;
          aborted = 1'b1;
          return;
        end
        bus.sin = bits[b];
        @(negedge rxclk);
        n++;
      end
    end
    bus.sin = 1'b1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ready) begin
        ok = 1'b1;
        return;
      end
      @(negedge rxclk);
    end
  endtask

  task automatic pulse_re();
    bus.re = 1'b1;
    @(negedge rxclk);
    bus.re = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.sin = 1'b1;
    bus.parity = 1'b0;
    bus.re = 1'b0;
    repeat (3) @(negedge rxclk);
    checks++;
    if (bus.dout !== 9'h000) begin
      failures++;
      $display("FAIL rst_dout got=%h exp=000", bus.dout);
    end
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready got=%b exp=0", bus.ready);
    end
    checks++;
    if (bus.framing_err !== 1'b0 || bus.overrun !== 1'b0
        || bus.break_det !== 1'b0) begin
      failures++;
      $display("FAIL rst_flags got=%b%b%b exp=000",
               bus.framing_err, bus.overrun, bus.break_det);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge rxclk);
  endtask

  task automatic rx_frame(input string nm, input logic [7:0] d,
                          input logic pb, input int lat);
    bit ok;
    bit ab;
    logic [8:0] e;
    send_frame(d, pb, 1'b1, 1'b1, -1, ab);
    wait_ready(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout ready got=0 exp=1", nm);
      exp_q.delete();
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.dout !== e) begin
      failures++;
      $display("FAIL %s_dout got=%h exp=%h", nm, bus.dout, e);
    end
    checks++;
    if (rise_cyc - start_cyc !== lat) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=%0d", nm,
               rise_cyc - start_cyc, lat);
    end
    checks++;
    if (bus.framing_err !== 1'b0) begin
      failures++;
      $display("FAIL %s_ferr got=%b exp=0", nm, bus.framing_err);
    end
  endtask

  task automatic test_basic();
    bus.parity = 1'b0;
    rx_frame("basic", 8'h64, 1'b0, 155);
    pulse_re();
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_re_clear ready got=%b exp=0", bus.ready);
    end
  endtask

  task automatic test_parity();
    bus.parity = 1'b1;
    rx_frame("par1", 8'h64, 1'b1, 171);
    pulse_re();
    rx_frame("par0", 8'hA5, 1'b0, 171);
    pulse_re();
    bus.parity = 1'b0;
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++;
      $display("FAIL par_re_clear ready got=%b exp=0", bus.ready);
    end
  endtask

  task automatic test_glitch();
    bus.sin = 1'b0;
    repeat (4) @(negedge rxclk);
    bus.sin = 1'b1;
    repeat (8) @(negedge rxclk);
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++;
      $display("FAIL glitch_ready got=%b exp=0", bus.ready);
    end
    rx_frame("post_glitch", 8'h5E, 1'b0, 155);
    pulse_re();
  endtask

  task automatic test_back_to_back();
    bit ab;
    logic [8:0] e;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, -1, ab);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, -1, ab);
    repeat (2) @(negedge rxclk);
    e = exp_q.pop_front();
    checks++;
    if (bus.dout !== e) begin
      failures++;
      $display("FAIL ovr_dout got=%h exp=%h", bus.dout, e);
    end
    checks++;
    if (bus.overrun !== 1'b1 || bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL ovr_flags got=ovr%b rdy%b exp=ovr1 rdy1",
               bus.overrun, bus.ready);
    end
    pulse_re();
    checks++;
    if (bus.overrun !== 1'b0 || bus.ready !== 1'b0) begin
      failures++;
      $display("FAIL ovr_clear got=ovr%b rdy%b exp=ovr0 rdy0",
               bus.overrun, bus.ready);
    end
  endtask

  task automatic test_break();
    bus.sin = 1'b0;
    repeat (200) @(negedge rxclk);
`ifdef UART_RX_BREAK_EN
    checks++;
    if (bus.break_det !== 1'b1 || bus.ready !== 1'b0) begin
      failures++;
      $display("FAIL brk_active got=brk%b rdy%b exp=brk1 rdy0",
               bus.break_det, bus.ready);
    end
`else
    checks++;
    if (bus.ready !== 1'b1 || bus.dout !== 9'h000) begin
      failures++;
      $display("FAIL brk_frame got=rdy%b dout%h exp=rdy1 dout000",
               bus.ready, bus.dout);
    end
    checks++;
    if (bus.framing_err !== 1'b1 || bus.break_det !== 1'b0) begin
      failures++;
      $display("FAIL brk_ferr got=fe%b brk%b exp=fe1 brk0",
               bus.framing_err, bus.break_det);
    end
`endif
    repeat (21) @(negedge rxclk);
    bus.sin = 1'b1;
    repeat (6) @(negedge rxclk);
    checks++;
    if (bus.break_det !== 1'b0) begin
      failures++;
      $display("FAIL brk_release got=%b exp=0", bus.break_det);
    end
    repeat (200) @(negedge rxclk);
`ifdef UART_RX_BREAK_EN
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++;
      $display("FAIL brk_no_rearm ready got=%b exp=0", bus.ready);
    end
`else
    checks++;
    if (bus.ready !== 1'b1 || bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL brk_no_rearm got=rdy%b ovr%b exp=rdy1 ovr0",
               bus.ready, bus.overrun);
    end
    pulse_re();
    checks++;
    if (bus.ready !== 1'b0 || bus.framing_err !== 1'b0) begin
      failures++;
      $display("FAIL brk_clear got=rdy%b fe%b exp=rdy0 fe0",
               bus.ready, bus.framing_err);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    bit ab;
    bit ok;
    logic [8:0] e;
    send_frame(8'h81, 1'b0, 1'b1, 1'b1, -1, ab);
    wait_ready(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || bus.dout !== e) begin
      failures++;
      $display("FAIL rmid_pre got=rdy%b dout%h exp=rdy1 dout%h",
               bus.ready, bus.dout, e);
    end
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 83, ab);
    #1;
    checks++;
    if (!ab || bus.dout !== 9'h000 || bus.ready !== 1'b0) begin
      failures++;
      $display("FAIL rmid_out got=rdy%b dout%h exp=rdy0 dout000",
               bus.ready, bus.dout);
    end
    checks++;
    if (bus.framing_err !== 1'b0 || bus.overrun !== 1'b0
        || bus.break_det !== 1'b0) begin
      failures++;
      $display("FAIL rmid_flags got=%b%b%b exp=000",
               bus.framing_err, bus.overrun, bus.break_det);
    end
    @(negedge rxclk);
    @(negedge rxclk);
    reset_n = 1'b1;
    repeat (40) @(negedge rxclk);
    checks++;
    if (bus.ready !== 1'b0) begin
      failures++;
      $display("FAIL rmid_no_partial ready got=%b exp=0", bus.ready);
    end
    rx_frame("rmid_next", 8'h3C, 1'b0, 155);
    pulse_re();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    rise_cyc = -1;
    rdy_prev = 1'b0;
    reset_n = 1'b0;
    bus.sin = 1'b1;
    bus.parity = 1'b0;
    bus.re = 1'b0;
    @(negedge rxclk);
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_back_to_back();
    test_break();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
